// File: rtl/mux2_pkg.sv
// Shared arithmetic definitions: default datapath width and the select-line
// encodings used by the adder and other mux2 users.
package mux2_pkg;

    localparam int unsigned ARITH_BUS_W = 4;

    typedef enum logic {
        SEL_D0 = 1'b0,
        SEL_D1 = 1'b1
    } sel_e;

endpackage : mux2_pkg

// File: rtl/mux2.sv
// Two-input word multiplexer with an optional output register, used as the
// adder's result-selection primitive or as a single pipeline stage.
module mux2
    import mux2_pkg::*;
#(
    parameter int unsigned WIDTH      = ARITH_BUS_W,
    parameter int unsigned REGISTERED = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic             selector,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] w_sel_word;

    // Only an explicit 1 picks d1; 0, X and Z all fall through to d0.
    always_comb begin
        w_sel_word = d0;
        if (selector == SEL_D1) begin
            w_sel_word = d1;
        end
    end

    if (REGISTERED != 0) begin : g_reg
        logic [WIDTH-1:0] r_out;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_out <= '0;
            end else begin
                r_out <= w_sel_word;
            end
        end

        assign out = r_out;
    end else begin : g_comb
        // Clock and reset are intentionally ignored in the combinational build.
        logic w_unused;
        assign w_unused = ^{clk, rst};
        assign out      = w_sel_word;
    end

endmodule : mux2

// File: tb/tb_mux2.sv
// Directed checks of mux2 in combinational and registered form at WIDTH=5.
module tb_mux2;

    localparam int unsigned W = 5;

    logic         clk;
    logic         rst;
    logic [W-1:0] d0;
    logic [W-1:0] d1;
    logic         selector;
    logic [W-1:0] out_c;
    logic [W-1:0] out_r;

    int unsigned n_vec;
    int unsigned n_bad;

    mux2 #(.WIDTH(W), .REGISTERED(0)) u_comb (
        .clk      (clk),
        .rst      (rst),
        .d0       (d0),
        .d1       (d1),
        .selector (selector),
        .out      (out_c)
    );

    mux2 #(.WIDTH(W), .REGISTERED(1)) u_reg (
        .clk      (clk),
        .rst      (rst),
        .d0       (d0),
        .d1       (d1),
        .selector (selector),
        .out      (out_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         rst;
        logic         sel;
        logic [W-1:0] d0;
        logic [W-1:0] d1;
        logic [W-1:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [W-1:0] act,
                         input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic edge_settle();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[9];

    initial begin
        n_vec = 0;
        n_bad = 0;

        vecs[0] = '{1'b0, 1'b0, 5'b00101, 5'b11010, 5'b00101};
        vecs[1] = '{1'b0, 1'b1, 5'b00101, 5'b11010, 5'b11010};
        vecs[2] = '{1'b0, 1'b0, 5'h1F,    5'h00,    5'h1F};
        vecs[3] = '{1'b0, 1'b1, 5'h1F,    5'h00,    5'h00};
        vecs[4] = '{1'b0, 1'b1, 5'h00,    5'h10,    5'h10};
        vecs[5] = '{1'b0, 1'b0, 5'h10,    5'h0F,    5'h10};
        vecs[6] = '{1'b0, 1'b1, 5'h0A,    5'h15,    5'h15};
        vecs[7] = '{1'b1, 1'b0, 5'h07,    5'h18,    5'h07};
        vecs[8] = '{1'b1, 1'b1, 5'h07,    5'h18,    5'h18};

        rst      = 1'b1;
        selector = 1'b0;
        d0       = '0;
        d1       = '0;

        // Combinational instance: zero latency, reset has no effect.
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            rst      = vecs[i].rst;
            selector = vecs[i].sel;
            d0       = vecs[i].d0;
            d1       = vecs[i].d1;
            #1;
            check($sformatf("comb_vec%0d", i), out_c, vecs[i].exp);
        end

        // Selector not driven to 1 must choose d0.
        @(negedge clk);
        rst      = 1'b0;
        d0       = 5'h03;
        d1       = 5'h1C;
        selector = 1'bx;
        #1;
        check("comb_sel_x", out_c, 5'h03);

        // Registered: reset held for two edges with d0 presented.
        @(negedge clk);
        rst      = 1'b1;
        d0       = 5'h1F;
        selector = 1'b0;
        edge_settle();
        check("reg_rst_edge1", out_r, 5'h00);
        edge_settle();
        check("reg_rst_edge2", out_r, 5'h00);

        // Release: first non-reset edge loads d1.
        @(negedge clk);
        rst      = 1'b0;
        selector = 1'b1;
        d1       = 5'h0A;
        #1;
        check("reg_pre_edge", out_r, 5'h00);
        edge_settle();
        check("reg_first_load", out_r, 5'h0A);

        // Selector toggling 0 -> 1 -> 0 across consecutive edges.
        @(negedge clk);
        d0       = 5'h01;
        d1       = 5'h10;
        selector = 1'b0;
        edge_settle();
        check("reg_tog0", out_r, 5'h01);
        @(negedge clk);
        selector = 1'b1;
        #1;
        check("reg_hold_between", out_r, 5'h01);
        edge_settle();
        check("reg_tog1", out_r, 5'h10);
        @(negedge clk);
        selector = 1'b0;
        edge_settle();
        check("reg_tog2", out_r, 5'h01);

        // Mid-cycle glitch on inputs is not captured.
        @(negedge clk);
        d0 = 5'h1E;
        #2;
        d0 = 5'h06;
        edge_settle();
        check("reg_edge_only", out_r, 5'h06);

        // Reset mid-stream discards the word, then reload after release.
        @(negedge clk);
        d1       = 5'h15;
        selector = 1'b1;
        rst      = 1'b1;
        edge_settle();
        check("reg_mid_rst", out_r, 5'h00);
        @(negedge clk);
        rst = 1'b0;
        edge_settle();
        check("reg_after_rst", out_r, 5'h15);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_mux2
